lag_measure_sequencer: RTL and testbench

Sequencer that turns the single-shot lag measurement into an automated multi-sample run. Arms the flash pattern in the video generator, waits for its start pulse, times the photo-sensor rising edge in 10 µs ticks, retries on timeout, and reports min/max/average over a power-of-two sample count. Sits in the 27 MHz `clock` domain between the crossed `starttrigger`, the synchronized sensor input and the result display/I2C readout.

---
 rtl/lag_measure_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_lag_measure_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_measure_sequencer.sv
// Automated multi-sample display-lag measurement sequencer.
// Arms the flash pattern, waits for the generator's start pulse and times the
// photo-sensor rising edge in CLOCK_DIVIDER-clock ticks. It retries on timeout
// and publishes min/max/average lag over 2**SAMPLES_LOG2 samples.
//
// Optional build macro: LAG_SENSOR_DEBOUNCE_EN
//   When defined, a sensor edge is accepted only after the sensor has been
//   high for 4 consecutive clocks following a low. SETTLE also uses this
//   debounced level.
//
// Ports:
//   clock, reset_n        27 MHz clock, asynchronous active-low reset
//   start, abort          begin a run / cancel a run (abort has priority)
//   starttrigger          one-cycle flash-start pulse from the video generator
//   sensor                synchronized photo-sensor, high = light
//   flash_enable          requests the flash pattern (ARM/MEASURE)
//   busy                  run in progress
//   sample_valid/value    per-sample pulse and lag in ticks
//   sample_timeout        pulse per timed-out sample
//   done                  end-of-run pulse
//   result_valid, error   run outcome
//   lag_min/max/avg       published run statistics in ticks
//   timeout_count         timeouts in the last/current run
module lag_measure_sequencer #(
    parameter int unsigned CLOCK_DIVIDER = 270,
    parameter int unsigned SAMPLES_LOG2  = 4,
    parameter int unsigned TIMEOUT_TICKS = 20000,
    parameter int unsigned SETTLE_TICKS  = 5000,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        starttrigger,
    input  logic        sensor,
    output logic        flash_enable,
    output logic        busy,
    output logic        sample_valid,
    output logic [15:0] sample_value,
    output logic        sample_timeout,
    output logic        done,
    output logic        result_valid,
    output logic        error,
    output logic [15:0] lag_min,
    output logic [15:0] lag_max,
    output logic [15:0] lag_avg,
    output logic [4:0]  timeout_count
);

    localparam int unsigned DIV_W  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int unsigned TICK_W = 16;
    localparam int unsigned IDX_W  = SAMPLES_LOG2 + 1;
    localparam int unsigned SUM_W  = 16 + SAMPLES_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [IDX_W-1:0]  sample_idx;
    logic [SUM_W-1:0]  sum;
    logic [15:0]       run_min;
    logic [15:0]       run_max;
    logic              run_err;

    logic rise_c;
    logic sensor_lvl_c;
    logic tick_wrap_c;
    logic settle_done_c;
    logic last_sample_c;
    logic retries_out_c;
    logic run_start_c;
    logic accept_c;
    logic timeout_hit_c;
    logic finish_c;

`ifdef LAG_SENSOR_DEBOUNCE_EN
    // Count consecutive high clocks; the 4th one (high_run == 3) is the accepted edge.
    logic [1:0] high_run;
    logic       sensor_db;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_run  <= '0;
            sensor_db <= 1'b0;
        end else if (!sensor) begin
            high_run  <= '0;
            sensor_db <= 1'b0;
        end else if (high_run != 2'd3) begin
            high_run  <= high_run + 2'd1;
        end else begin
            sensor_db <= 1'b1;
        end
    end

    assign rise_c       = sensor && (high_run == 2'd3) && !sensor_db;
    // Falls immediately with the raw sensor so SETTLE restarts without delay.
    assign sensor_lvl_c = sensor && (sensor_db || (high_run == 2'd3));
`else
    logic sensor_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sensor_q <= 1'b0;
        else          sensor_q <= sensor;
    end

    assign rise_c       = sensor && !sensor_q;
    assign sensor_lvl_c = sensor;
`endif

    assign tick_wrap_c   = (div_cnt == DIV_W'(CLOCK_DIVIDER - 1));
    assign settle_done_c = !sensor_lvl_c && tick_wrap_c &&
                           (tick_cnt == TICK_W'(SETTLE_TICKS - 1));
    assign last_sample_c = (sample_idx == IDX_W'((1 << SAMPLES_LOG2) - 1));
    assign retries_out_c = (timeout_count == 5'(MAX_RETRIES - 1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state and event decode; abort overrides everything
    always_comb begin
        state_next    = state;
        run_start_c   = 1'b0;
        accept_c      = 1'b0;
        timeout_hit_c = 1'b0;
        finish_c      = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        run_start_c = 1'b1;
                        state_next  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_done_c) state_next = S_ARM;
                end
                S_ARM: begin
                    if (starttrigger) state_next = S_MEASURE;
                end
                S_MEASURE: begin
                    // An edge in the timeout cycle still counts as a sample.
                    if (rise_c) begin
                        accept_c   = 1'b1;
                        state_next = last_sample_c ? S_DONE : S_SETTLE;
                    end else if (tick_cnt == TICK_W'(TIMEOUT_TICKS)) begin
                        timeout_hit_c = 1'b1;
                        state_next    = retries_out_c ? S_DONE : S_SETTLE;
                    end
                end
                S_DONE: begin
                    finish_c   = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Tick timebase: cleared on every state change and while SETTLE sees light
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if ((state_next != state) || ((state == S_SETTLE) && sensor_lvl_c)) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick_wrap_c) begin
            div_cnt  <= '0;
            tick_cnt <= tick_cnt + TICK_W'(1);
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    // Run accumulators and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flash_enable   <= 1'b0;
            busy           <= 1'b0;
            sample_valid   <= 1'b0;
            sample_value   <= '0;
            sample_timeout <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            error          <= 1'b0;
            lag_min        <= 16'hFFFF;
            lag_max        <= '0;
            lag_avg        <= '0;
            timeout_count  <= '0;
            sample_idx     <= '0;
            sum            <= '0;
            run_min        <= 16'hFFFF;
            run_max        <= '0;
            run_err        <= 1'b0;
        end else begin
            sample_valid   <= 1'b0;
            sample_timeout <= 1'b0;
            done           <= 1'b0;
            flash_enable   <= (state_next == S_ARM) || (state_next == S_MEASURE);
            // Held through the done pulse, low the cycle after.
            busy           <= (state_next != S_IDLE) || finish_c;

            if (run_start_c) begin
                sample_idx    <= '0;
                sum           <= '0;
                run_min       <= 16'hFFFF;
                run_max       <= '0;
                run_err       <= 1'b0;
                timeout_count <= '0;
                error         <= 1'b0;
                result_valid  <= 1'b0;
            end

            if (accept_c) begin
                sample_valid <= 1'b1;
                sample_value <= tick_cnt;
                sum          <= sum + SUM_W'(tick_cnt);
                sample_idx   <= sample_idx + IDX_W'(1);
                if (tick_cnt < run_min) run_min <= tick_cnt;
                if (tick_cnt > run_max) run_max <= tick_cnt;
            end

            if (timeout_hit_c) begin
                sample_timeout <= 1'b1;
                timeout_count  <= timeout_count + 5'd1;
                if (retries_out_c) run_err <= 1'b1;
            end

            if (finish_c) begin
                done         <= 1'b1;
                lag_min      <= run_min;
                lag_max      <= run_max;
                lag_avg      <= 16'(sum >> SAMPLES_LOG2);
                result_valid <= !run_err;
                error        <= run_err;
            end
        end
    end

endmodule

// File: tb/tb_lag_measure_sequencer.sv
module tb_lag_measure_sequencer;

    localparam int CD  = 5;
    localparam int SL2 = 2;
    localparam int TO  = 300;
    localparam int ST  = 8;
    localparam int MR  = 3;
    localparam int NS  = 1 << SL2;
`ifdef LAG_SENSOR_DEBOUNCE_EN
    localparam int DEB_LAT = 3;
`else
    localparam int DEB_LAT = 0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        starttrigger;
    logic        sensor;
    logic        flash_enable;
    logic        busy;
    logic        sample_valid;
    logic [15:0] sample_value;
    logic        sample_timeout;
    logic        done;
    logic        result_valid;
    logic        error;
    logic [15:0] lag_min;
    logic [15:0] lag_max;
    logic [15:0] lag_avg;
    logic [4:0]  timeout_count;

    int checks   = 0;
    int failures = 0;
    int lag_t[NS];
    int jit_t[NS];
    int gl_t[NS];
    int exp_min = 65535;
    int exp_max = 0;
    int exp_avg = 0;

    lag_measure_sequencer #(
        .CLOCK_DIVIDER (CD),
        .SAMPLES_LOG2  (SL2),
        .TIMEOUT_TICKS (TO),
        .SETTLE_TICKS  (ST),
        .MAX_RETRIES   (MR)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .starttrigger   (starttrigger),
        .sensor         (sensor),
        .flash_enable   (flash_enable),
        .busy           (busy),
        .sample_valid   (sample_valid),
        .sample_value   (sample_value),
        .sample_timeout (sample_timeout),
        .done           (done),
        .result_valid   (result_valid),
        .error          (error),
        .lag_min        (lag_min),
        .lag_max        (lag_max),
        .lag_avg        (lag_avg),
        .timeout_count  (timeout_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_flash();
        int n;
        n = 0;
        while (!flash_enable && n < 3000) begin
            tick();
            n++;
        end
        chk("flash_arm", 32'(flash_enable), 32'd1);
    endtask

    task automatic trig();
        repeat ($urandom_range(0, 3)) tick();
        starttrigger = 1'b1;
        tick();
        starttrigger = 1'b0;
    endtask

    // Edge offsets m count clocks after the trigger clock; the lag is the number
    // of whole CD-clock periods from the clock after the trigger to acceptance.
    task automatic do_sample(input int lag, input int jit, input int gl, output int val);
        int e_solid;
        int g;
        int e_acc;
        int got;
        int tos;
        e_solid = 1 + lag * CD + jit;
        g       = (gl >= 0) ? 1 + gl * CD : -100;
        e_acc   = (gl >= 0 && DEB_LAT == 0) ? g : e_solid + DEB_LAT;
        val     = (e_acc - 1) / CD;
        got     = -1;
        tos     = 0;
        for (int m = 1; m <= e_acc + 5; m++) begin
            sensor = (m >= e_solid) || (m == g) || (m == g + 1);
            tick();
            if (sample_timeout) tos++;
            if (sample_valid) begin
                got = m;
                break;
            end
        end
        sensor = 1'b0;
        chk("valid_cycle", 32'(got), 32'(e_acc));
        chk("sample_value", 32'(sample_value), 32'(val));
        chk("flash_drop", 32'(flash_enable), 32'd0);
        chk("no_timeout", 32'(tos), 32'd0);
    endtask

    task automatic do_run();
        int v;
        int mn;
        int mx;
        int sm;
        mn = 65535;
        mx = 0;
        sm = 0;
        pulse_start();
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < NS; i++) begin
            wait_flash();
            trig();
            do_sample(lag_t[i], jit_t[i], gl_t[i], v);
            if (v < mn) mn = v;
            if (v > mx) mx = v;
            sm += v;
            if (i == 1) pulse_start();
        end
        exp_min = mn;
        exp_max = mx;
        exp_avg = sm / NS;
        tick();
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("error", 32'(error), 32'd0);
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("lag_min", 32'(lag_min), 32'(exp_min));
        chk("lag_max", 32'(lag_max), 32'(exp_max));
        chk("lag_avg", 32'(lag_avg), 32'(exp_avg));
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int cnt;
        int tos;

        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        starttrigger = 1'b0;
        sensor       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_flash", 32'(flash_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_value", 32'(sample_value), 32'd0);
        chk("rst_timeout", 32'(sample_timeout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_min", 32'(lag_min), 32'hFFFF);
        chk("rst_max", 32'(lag_max), 32'd0);
        chk("rst_avg", 32'(lag_avg), 32'd0);
        chk("rst_tcount", 32'(timeout_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Constant lag with random sub-tick jitter
        for (int i = 0; i < NS; i++) begin
            lag_t[i] = 30;
            jit_t[i] = $urandom_range(0, CD - 1);
            gl_t[i]  = -1;
        end
        do_run();

        // Spread lags
        lag_t = '{10, 20, 30, 40};
        for (int i = 0; i < NS; i++) begin
            jit_t[i] = $urandom_range(0, CD - 1);
            gl_t[i]  = -1;
        end
        do_run();

        // Abort mid-measure keeps previous statistics
        pulse_start();
        wait_flash();
        trig();
        repeat (20) tick();
        chk("abort_pre_flash", 32'(flash_enable), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_flash", 32'(flash_enable), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        cnt = 0;
        repeat (30) begin
            tick();
            if (done) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        chk("abort_min", 32'(lag_min), 32'(exp_min));
        chk("abort_max", 32'(lag_max), 32'(exp_max));
        chk("abort_avg", 32'(lag_avg), 32'(exp_avg));

        // Sensor held high blocks arming; triggers outside ARM are ignored
        sensor = 1'b1;
        pulse_start();
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            starttrigger = (k == 30);
            tick();
            if (flash_enable) cnt++;
        end
        starttrigger = 1'b0;
        chk("settle_hold_high", 32'(cnt), 32'd0);
        sensor = 1'b0;
        cnt = 0;
        for (int k = 0; k < ST * CD - 1; k++) begin
            starttrigger = (k == 10);
            tick();
            if (flash_enable) cnt++;
        end
        starttrigger = 1'b0;
        chk("settle_early_arm", 32'(cnt), 32'd0);
        tick();
        chk("settle_arm_time", 32'(flash_enable), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("settle_abort_busy", 32'(busy), 32'd0);

        // Boundaries: zero lag, edge coinciding with timeout, glitch then solid high
        lag_t = '{0, (DEB_LAT != 0) ? TO - 1 : TO, 120, 0};
        lag_t[3] = $urandom_range(1, 250);
        jit_t = '{0, 0, 0, 0};
        jit_t[0] = $urandom_range(0, CD - 1);
        jit_t[3] = $urandom_range(0, CD - 1);
        gl_t = '{-1, -1, 50, -1};
        do_run();

        // Sensor never rises: retries exhausted
        pulse_start();
        chk("to_busy_start", 32'(busy), 32'd1);
        for (int r = 0; r < MR; r++) begin
            wait_flash();
            trig();
            tos = 0;
            repeat (TO * CD) begin
                tick();
                if (sample_timeout || sample_valid) tos++;
            end
            chk("timeout_early", 32'(tos), 32'd0);
            tick();
            chk("timeout_pulse", 32'(sample_timeout), 32'd1);
            chk("timeout_count", 32'(timeout_count), 32'(r + 1));
            chk("timeout_flash", 32'(flash_enable), 32'd0);
        end
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_error", 32'(error), 32'd1);
        chk("to_result_valid", 32'(result_valid), 32'd0);
        chk("to_count_final", 32'(timeout_count), 32'(MR));
        tick();
        chk("to_busy_end", 32'(busy), 32'd0);

        // Random lags after an error run
        for (int i = 0; i < NS; i++) begin
            lag_t[i] = $urandom_range(1, 250);
            jit_t[i] = $urandom_range(0, CD - 1);
            gl_t[i]  = -1;
        end
        do_run();
        chk("final_tcount", 32'(timeout_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
